// File: rtl/ble_config_loader.sv
// ble_config_loader: serial sync-locked loader that commits parity-checked per-BLE LUT/select frames atomically
module ble_config_loader #(
  parameter int          NUM_BLE  = 9,
  parameter int          LUT_BITS = 16,
  parameter logic [15:0] SYNC     = 16'hA5C3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_din,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic                         cfg_restart,
  output logic [NUM_BLE*LUT_BITS-1:0]  lut_cfg,
  output logic [NUM_BLE-1:0]           sel_cfg,
  output logic                         cfg_done,
  output logic                         cfg_err
);
  localparam int FW  = LUT_BITS + 1;
  localparam int BW  = $clog2(LUT_BITS + 2);
  localparam int FCW = $clog2(NUM_BLE);
  typedef enum logic [1:0] {HUNT, LOAD, DONE, ERR} state_t;
  state_t state, state_nxt;
  logic [14:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic [FCW-1:0] frame_cnt;
  logic [FW-1:0] fr;
  logic par;
  logic [LUT_BITS-1:0] sh_lut [NUM_BLE];
  logic [NUM_BLE-1:0] sh_sel;
  logic xfer, sync_hit, par_bit, par_ok, last_frame, commit, fail, ready_nxt;
  logic [NUM_BLE*LUT_BITS-1:0] lut_nxt;
  logic [NUM_BLE-1:0] sel_nxt;
  // restart discards any bit offered in the same cycle
  assign xfer       = cfg_valid && cfg_ready && !cfg_restart;
  assign sync_hit   = xfer && state == HUNT && {shreg, cfg_din} == SYNC;
  assign par_bit    = xfer && state == LOAD && bit_cnt == BW'(LUT_BITS + 1);
  assign par_ok     = !(par ^ cfg_din);
  assign last_frame = frame_cnt == FCW'(NUM_BLE - 1);
  assign commit     = par_bit && par_ok && last_frame;
  assign fail       = par_bit && !par_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_nxt;
  always_comb
    state_nxt = cfg_restart ? HUNT :
                sync_hit    ? LOAD :
                commit      ? DONE :
                fail        ? ERR  : state;
  // final frame bypasses the shadow so the whole array commits on one edge
  always_comb begin
    ready_nxt = state_nxt == HUNT || state_nxt == LOAD;
    lut_nxt = '0;
    sel_nxt = '0;
    for (int i = 0; i < NUM_BLE; i++) begin
      lut_nxt[LUT_BITS*i +: LUT_BITS] = (i == NUM_BLE - 1) ? fr[FW-1:1] : sh_lut[i];
      sel_nxt[i] = (i == NUM_BLE - 1) ? fr[0] : sh_sel[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      lut_cfg   <= '0;
      sel_cfg   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      fr        <= '0;
      par       <= 1'b0;
      sh_sel    <= '0;
      for (int i = 0; i < NUM_BLE; i++) sh_lut[i] <= '0;
    end else begin
      cfg_ready <= ready_nxt;
      if (cfg_restart) begin
        shreg     <= '0;
        bit_cnt   <= '0;
        frame_cnt <= '0;
        par       <= 1'b0;
        cfg_done  <= 1'b0;
        cfg_err   <= 1'b0;
      end else if (xfer) begin
        if (state == HUNT) begin
          shreg     <= {shreg[13:0], cfg_din};
          bit_cnt   <= '0;
          frame_cnt <= '0;
          par       <= 1'b0;
        end else begin
          fr <= {fr[FW-2:0], cfg_din};
          if (par_bit) begin
            bit_cnt <= '0;
            par     <= 1'b0;
            if (par_ok) begin
              sh_lut[frame_cnt] <= fr[FW-1:1];
              sh_sel[frame_cnt] <= fr[0];
              frame_cnt <= frame_cnt + 1'b1;
            end
            if (commit) begin
              lut_cfg  <= lut_nxt;
              sel_cfg  <= sel_nxt;
              cfg_done <= 1'b1;
            end
            if (fail) cfg_err <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            par     <= par ^ cfg_din;
          end
        end
      end
    end
endmodule

// File: tb/tb_ble_config_loader.sv
// tb_ble_config_loader: scoreboard bench driving serial bitstreams into ble_config_loader
module tb_ble_config_loader;
  logic clk = 1'b0, rst_n = 1'b0, cfg_din = 1'b0, cfg_valid = 1'b0, cfg_restart = 1'b0;
  logic cfg_ready, cfg_done, cfg_err;
  logic [143:0] lut_cfg;
  logic [8:0] sel_cfg;
  always #5 clk = ~clk;
  ble_config_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_din(cfg_din), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_restart(cfg_restart), .lut_cfg(lut_cfg), .sel_cfg(sel_cfg), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );
  typedef struct {
    logic [143:0] lut;
    logic [8:0]   sel;
    logic         done;
    logic         err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic bits[$];
  logic [143:0] mdl_lut = '0;
  logic [8:0] mdl_sel = '0;
  int checks = 0, fails = 0;
  function automatic logic [15:0] lut_of(int mode, int i);
    return mode == 1 ? 16'hFFFF : 16'(32'h1111 * i);
  endfunction
  function automatic logic sel_of(int mode, int i);
    return mode == 1 ? 1'b1 : i[0];
  endfunction
  function automatic logic [143:0] full_lut(int mode);
    logic [143:0] r;
    for (int i = 0; i < 9; i++) r[16*i +: 16] = lut_of(mode, i);
    return r;
  endfunction
  function automatic logic [8:0] full_sel(int mode);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = sel_of(mode, i);
    return r;
  endfunction
  task automatic build_stream(input int mode, input int bad);
    logic [15:0] s, l;
    logic sl;
    s = 16'hA5C3;
    for (int b = 15; b >= 0; b--) bits.push_back(s[b]);
    for (int i = 0; i < 9; i++) begin
      l = lut_of(mode, i);
      sl = sel_of(mode, i);
      for (int b = 15; b >= 0; b--) bits.push_back(l[b]);
      bits.push_back(sl);
      bits.push_back((^{l, sl}) ^ (i == bad));
      if (i == bad) break;
    end
  endtask
  task automatic send_bit(input logic b, input int gap);
    int n;
    while ($urandom_range(99) < gap) begin
      cfg_valid = 1'b0;
      cfg_din = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    cfg_din = b;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: cfg_ready=%b required 1", cfg_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic send_bits(input int n, input int gap);
    for (int k = 0; k < n; k++) send_bit(bits.pop_front(), gap);
  endtask
  task automatic wait_result();
    int n;
    n = 0;
    while (!(cfg_done || cfg_err) && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask
  task automatic restart_pulse();
    cfg_restart = 1'b1;
    cfg_valid = 1'b1;
    cfg_din = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_restart = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_ready, cfg_done, cfg_err} !== 3'b100) begin
      fails++;
      $display("FAIL restart_flags: ready/done/err=%b required 100", {cfg_ready, cfg_done, cfg_err});
    end
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({lut_cfg, sel_cfg, cfg_ready, cfg_done, cfg_err} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: ready=%b done=%b err=%b sel=%h required all 0", cfg_ready, cfg_done, cfg_err, sel_cfg);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_early: cfg_ready=%b required 0", cfg_ready);
    end
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_rise: cfg_ready=%b required 1", cfg_ready);
    end
  endtask
  task automatic test_good_load(input int mode, input int gap, input string nm);
    build_stream(mode, -1);
    q.push_back('{full_lut(mode), full_sel(mode), 1'b1, 1'b0});
    mdl_lut = full_lut(mode);
    mdl_sel = full_sel(mode);
    send_bits(bits.size() - 1, gap);
    checks++;
    if ({cfg_done, cfg_err, cfg_ready} !== 3'b001) begin
      fails++;
      $display("FAIL %s_early: done/err/ready=%b required 001", nm, {cfg_done, cfg_err, cfg_ready});
    end
    send_bits(1, gap);
    wait_result();
    e = q.pop_front();
    checks++;
    if ({lut_cfg, sel_cfg, cfg_done, cfg_err, cfg_ready} !== {e.lut, e.sel, e.done, e.err, 1'b0}) begin
      fails++;
      $display("FAIL %s: lut=%h sel=%h done=%b err=%b ready=%b required lut=%h sel=%h done=%b err=%b ready=0",
               nm, lut_cfg, sel_cfg, cfg_done, cfg_err, cfg_ready, e.lut, e.sel, e.done, e.err);
    end
  endtask
  task automatic test_parity_error();
    restart_pulse();
    build_stream(0, 4);
    q.push_back('{mdl_lut, mdl_sel, 1'b0, 1'b1});
    checks++;
    if (bits.size() != 106) begin
      fails++;
      $display("FAIL parity_stream_len: got %0d required 106", bits.size());
    end
    send_bits(105, 0);
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b01) begin
      fails++;
      $display("FAIL parity_early: err/ready=%b required 01", {cfg_err, cfg_ready});
    end
    send_bits(1, 0);
    wait_result();
    e = q.pop_front();
    checks++;
    if ({lut_cfg, sel_cfg, cfg_done, cfg_err, cfg_ready} !== {e.lut, e.sel, e.done, e.err, 1'b0}) begin
      fails++;
      $display("FAIL parity_error: lut=%h sel=%h done=%b err=%b ready=%b required lut=%h sel=%h done=0 err=1 ready=0",
               lut_cfg, sel_cfg, cfg_done, cfg_err, cfg_ready, e.lut, e.sel);
    end
  endtask
  task automatic test_sync_hunt();
    logic [7:0] pre;
    restart_pulse();
    pre = 8'hA5;
    for (int b = 7; b >= 0; b--) bits.push_back(pre[b]);
    test_good_load(1, 0, "sync_hunt");
  endtask
  task automatic test_gaps();
    restart_pulse();
    test_good_load(0, 40, "gaps");
  endtask
  task automatic test_restart();
    restart_pulse();
    build_stream(0, -1);
    send_bits(16 + 3*18 + 5, 0);
    bits.delete();
    restart_pulse();
    checks++;
    if ({lut_cfg, sel_cfg} !== {mdl_lut, mdl_sel}) begin
      fails++;
      $display("FAIL restart_keep: lut=%h sel=%h required lut=%h sel=%h", lut_cfg, sel_cfg, mdl_lut, mdl_sel);
    end
    build_stream(1, -1);
    q.push_back('{full_lut(1), full_sel(1), 1'b1, 1'b0});
    send_bits(bits.size() - 1, 0);
    checks++;
    if ({lut_cfg, sel_cfg, cfg_done} !== {mdl_lut, mdl_sel, 1'b0}) begin
      fails++;
      $display("FAIL restart_hold: lut=%h sel=%h done=%b required lut=%h sel=%h done=0", lut_cfg, sel_cfg, cfg_done, mdl_lut, mdl_sel);
    end
    send_bits(1, 0);
    wait_result();
    e = q.pop_front();
    mdl_lut = e.lut;
    mdl_sel = e.sel;
    checks++;
    if ({lut_cfg, sel_cfg, cfg_done, cfg_err} !== {e.lut, e.sel, e.done, e.err}) begin
      fails++;
      $display("FAIL restart_reload: lut=%h sel=%h done=%b err=%b required lut=%h sel=%h done=1 err=0",
               lut_cfg, sel_cfg, cfg_done, cfg_err, e.lut, e.sel);
    end
  endtask
  task automatic test_async_reset();
    restart_pulse();
    build_stream(0, -1);
    send_bits(16 + 5*18 + 3, 0);
    bits.delete();
    rst_n = 1'b0;
    #1;
    mdl_lut = '0;
    mdl_sel = '0;
    checks++;
    if ({lut_cfg, sel_cfg, cfg_ready, cfg_done, cfg_err} !== {mdl_lut, mdl_sel, 3'b000}) begin
      fails++;
      $display("FAIL async_reset: lut=%h sel=%h ready=%b done=%b err=%b required all 0", lut_cfg, sel_cfg, cfg_ready, cfg_done, cfg_err);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cfg_ready, cfg_done, cfg_err} !== 3'b100) begin
      fails++;
      $display("FAIL async_reset_recover: ready/done/err=%b required 100", {cfg_ready, cfg_done, cfg_err});
    end
  endtask
  initial begin
    test_reset();
    test_good_load(0, 0, "good_load");
    test_parity_error();
    test_sync_hunt();
    test_gaps();
    test_restart();
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ble_config_loader.md
# ble_config_loader

Serial configuration loader for the 3x3 logic-block array. It accepts a bit-serial bitstream over a valid/ready handshake and locks onto a sync word. It then collects one parity-protected frame per BLE: LUT contents plus the output-select bit that drives each BLE's output mux (LUT path vs flip-flop path). Frames go into shadow registers, and all BLE configuration outputs are committed in one atomic update only when every frame passes parity. It is the write side of the per-BLE configuration that the BLE datapath reads.

## Interface
- NUM_BLE, 9, number of BLEs configured (3x3 array)
- LUT_BITS, 16, LUT truth-table bits per BLE (4-input LUT)
- SYNC, 16'hA5C3, sync word preceding the frames
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_din  in  1  serial bitstream bit
- cfg_valid  in  1  cfg_din valid this cycle
- cfg_ready  out  1  loader accepts a bit; a bit transfers on a cycle with cfg_valid && cfg_ready
- cfg_restart  in  1  single-cycle pulse: abandon current activity, return to HUNT
- lut_cfg  out  NUM_BLE*LUT_BITS  committed LUT contents; BLE i at [LUT_BITS*i +: LUT_BITS]
- sel_cfg  out  NUM_BLE  committed BLE output-mux select; bit i for BLE i (0 = LUT output, 1 = FF output)
- cfg_done  out  1  level: last load committed successfully
- cfg_err  out  1  level: last load aborted on parity error

## Operation
- The one clock is clk. Reset is asynchronous, active-low, on rst_n.
- Frame format: LUT_BITS+2 bits, sent MSB first: lut[LUT_BITS-1] … lut[0], sel, parity.
  - Even parity: XOR of all LUT_BITS+2 bits must be 0.
  - Frames are sent in order BLE 0 first, BLE NUM_BLE-1 last.
- Bitstream: SYNC (MSB first), then NUM_BLE frames. There is no trailer.
- State machine: HUNT, LOAD, DONE, ERR.
- HUNT: each accepted bit shifts into a 16-bit sliding register.
  - The next state is LOAD when {shreg[14:0], cfg_din} == SYNC.
  - Sliding matches handle overlapping prefixes.
  - On entering LOAD, the bit counter and frame counter are cleared.
- LOAD: accepted bits shift into the frame register. The bit counter runs 0..LUT_BITS+1.
  - On the parity bit with the parity check passing: the frame is written to shadow slot frame_cnt and frame_cnt increments.
    - If it was the last frame: shadow (including this frame) copies to lut_cfg/sel_cfg, cfg_done←1, state←DONE.
  - On the parity bit with the parity check failing: cfg_err←1, state←ERR. The shadow is discarded and lut_cfg/sel_cfg are unchanged.
- DONE / ERR: cfg_ready=0, and the state holds until cfg_restart.
- cfg_restart, in any state:
  - Next state HUNT; the sync register, counters, cfg_done and cfg_err are cleared.
  - lut_cfg/sel_cfg keep their last committed value.
  - Restart wins over a simultaneous bit transfer; that bit is discarded.
- cfg_valid=0 cycles stall all state; counters hold. Gaps of any length are legal.
- Reset mid-load is the same as a fresh reset: committed configuration returns to 0.

## Timing
- Reset values:
  - cfg_ready=0, cfg_done=0, cfg_err=0.
  - lut_cfg=0, sel_cfg=0. All BLEs select the LUT output.
  - State HUNT.
- cfg_ready is registered. It rises on the first clk edge after rst_n deasserts. It is 1 in HUNT and LOAD, and falls on the edge that enters DONE/ERR.
- Commit latency: lut_cfg, sel_cfg and cfg_done update on the same edge that accepts the last frame's parity bit. The new values are visible the following cycle.
- cfg_err rises on the edge accepting the failing parity bit.
- Minimum load length is 16 + NUM_BLE*(LUT_BITS+2) accepted bits: 178 for the defaults.
- Restart takes effect on the edge where cfg_restart=1. cfg_ready is 1 the next cycle.
- Throughput: one bit per cycle, with no bubbles between sync and frames or between frames.

## Test plan
- Reset response:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Required: during reset all outputs are 0; cfg_ready=1 exactly one cycle after release.
- Good load:
  - Stimulus: SYNC, then BLE i with lut=16'h1111*i, sel=i[0] and correct parity, continuous valid.
  - Required: cfg_done=1 the cycle after bit 178; lut_cfg[16*i+:16]=16'h1111*i; sel_cfg=9'h0AA; cfg_ready=0.
- Parity error:
  - Stimulus: same stream as the good load, with the parity bit of frame 4 flipped, after a prior good load.
  - Required: cfg_err=1 the cycle after bit 16+5*18=106; lut_cfg/sel_cfg unchanged; cfg_done=0; cfg_ready=0.
- Sync hunt:
  - Stimulus: prefix 8'hA5, then a full good load.
  - Required: the loader locks on the true SYNC (not the leading A5) and commits the correct values.
- Handshake gaps:
  - Stimulus: good load with cfg_valid randomly deasserted about 40% of cycles.
  - Required: results identical to the good load.
- Restart and async reset mid-load:
  - Stimulus: cfg_restart during frame 3, then a full load with lut=16'hFFFF for all BLEs.
    - Required: committed values are unchanged until the second load completes, then lut_cfg is all ones.
  - Stimulus: rst_n pulsed low during frame 5, with no clock edge while low.
    - Required: outputs are 0 immediately.
